// File: rtl/sipo_deser_pkg.sv
// Shared constants and elaboration-time helpers for the sipo_deser deserializer.
// Build option: SIPO_DESER_PARITY_EN appends one even-parity bit to every frame.
package sipo_deser_pkg;

  // Bit-order encodings for the LSB_FIRST parameter.
  localparam int ORDER_MSB_FIRST = 0;  // first received bit ends up in the word MSB
  localparam int ORDER_LSB_FIRST = 1;  // first received bit ends up in the word LSB

`ifdef SIPO_DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial bits per frame: the data bits plus the trailing parity bit when enabled.
  function automatic int frame_len_f(input int width);
    return width + (PARITY_EN ? 1 : 0);
  endfunction

  // Width of the in-frame bit counter; it must be able to hold the value FRAME_LEN.
  function automatic int cnt_width_f(input int width);
    return $clog2(frame_len_f(width) + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and frame counter for sipo_deser.
// It assembles the data bits in the selected order and pulses frame_done on the
// edge that samples the last bit of a frame. The parity bit, when SIPO_DESER_PARITY_EN
// is defined, is counted but is not shifted in.
module sipo_shift_core
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = ORDER_MSB_FIRST,
  parameter int FRAME_LEN = frame_len_f(WIDTH),
  parameter int CW        = cnt_width_f(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             data_bit;

  // Next shift/count state; clear wins over a valid bit and suppresses completion.
  always_comb begin
    shifted    = (LSB_FIRST == ORDER_LSB_FIRST) ? {serial_in, sreg_q[WIDTH-1:1]}
                                                : {sreg_q[WIDTH-2:0], serial_in};
    last_bit   = (cnt_q == CW'(FRAME_LEN - 1));
    data_bit   = (int'(cnt_q) < WIDTH);
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    if (clear) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (serial_valid) begin
      if (data_bit) sreg_d = shifted;
      if (last_bit) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Shift register and counter flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // With parity the data bits are already in sreg when the parity bit arrives;
  // without it the final data bit is still on serial_in during the completing edge.
  assign word = PARITY_EN ? sreg_q : shifted;
  assign cnt  = cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserializer with a one-entry valid/ready
// output register and a sticky overrun flag.
// Build option: SIPO_DESER_PARITY_EN adds a trailing even-parity bit per frame and
// drives parity_err; without it parity_err is tied low and the ports are unchanged.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = ORDER_MSB_FIRST,
  parameter int CW        = cnt_width_f(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] word;
  logic             frame_done;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] parallel_out_q, parallel_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             drain, load, drop;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .clear        (clear),
    .word         (word),
    .cnt          (cnt),
    .frame_done   (frame_done)
  );

  // Output register: a completed word loads when the slot is free or draining this cycle.
  always_comb begin
    drain          = out_valid_q && out_ready;
    load           = frame_done && (!out_valid_q || drain);
    drop           = frame_done && !load;
    parallel_out_d = load ? word : parallel_out_q;
    out_valid_d    = load ? 1'b1 : (drain ? 1'b0 : out_valid_q);
    overrun_d      = clear ? 1'b0 : (drop ? 1'b1 : overrun_q);
  end

  // Output, valid and overrun flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_out_q <= '0;
      out_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      parallel_out_q <= parallel_out_d;
      out_valid_q    <= out_valid_d;
      overrun_q      <= overrun_d;
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Parity status travels with the word it describes; dropped words leave it alone.
  always_comb begin
    parity_err_d = load ? ^{word, serial_in} : parity_err_q;
  end

  // Parity status flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign parallel_out = parallel_out_q;
  assign out_valid    = out_valid_q;
  assign overrun      = overrun_q;
  assign bit_count    = cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=4), one MSB-first and one LSB-first instance
// sharing the same stimulus.
module tb_sipo_deser;

  localparam int W   = 4;
  localparam int CW  = sipo_deser_pkg::cnt_width_f(W);
  localparam bit PAR = sipo_deser_pkg::PARITY_EN;

  logic          clk = 1'b0;
  logic          reset;
  logic          serial_in, serial_valid, clear, out_ready;
  logic [W-1:0]  po_m, po_l;
  logic          ov_m, ov_l, orun_m, orun_l, perr_m, perr_l;
  logic [CW-1:0] bc_m, bc_l;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .parallel_out(po_m), .out_valid(ov_m), .out_ready(out_ready),
    .overrun(orun_m), .parity_err(perr_m), .bit_count(bc_m));

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .parallel_out(po_l), .out_valid(ov_l), .out_ready(out_ready),
    .overrun(orun_l), .parity_err(perr_l), .bit_count(bc_l));

  typedef struct {
    logic [W-1:0] bits;     // bits[3] is sent first
    logic [W-1:0] exp_msb;
    logic [W-1:0] exp_lsb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Drive one qualified bit; returns 1 time unit after the sampling edge.
  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    @(posedge clk); #1;
    serial_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // One frame; optionally raise out_ready just before the final frame bit.
  task automatic send_frame(input logic [W-1:0] w, input logic par, input logic ready_last);
    for (int i = W - 1; i >= 0; i--) begin
      if (ready_last && i == 0 && !PAR) out_ready = 1'b1;
      send_bit(w[i]);
    end
    if (PAR) begin
      if (ready_last) out_ready = 1'b1;
      send_bit(par);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_frame(w, ^w, 1'b0);
  endtask

  initial begin
    vecs[0] = '{4'b1010, 4'b1010, 4'b0101};
    vecs[1] = '{4'b1100, 4'b1100, 4'b0011};
    vecs[2] = '{4'b0001, 4'b0001, 4'b1000};
    vecs[3] = '{4'b1111, 4'b1111, 4'b1111};
    vecs[4] = '{4'b0110, 4'b0110, 4'b0110};
    vecs[5] = '{4'b1101, 4'b1101, 4'b1011};

    reset = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_po",   po_m,   0);
    chk("rst_ov",   ov_m,   0);
    chk("rst_orun", orun_m, 0);
    chk("rst_perr", perr_m, 0);
    chk("rst_bc",   bc_m,   0);
    reset = 1'b0;
    idle_cycle();

    // Back-to-back frames with the consumer always ready.
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].bits);
      chk($sformatf("tbl%0d_po_msb", v), po_m, vecs[v].exp_msb);
      chk($sformatf("tbl%0d_po_lsb", v), po_l, vecs[v].exp_lsb);
      chk($sformatf("tbl%0d_ov", v),     ov_m, 1);
      chk($sformatf("tbl%0d_orun", v),   orun_m, 0);
      chk($sformatf("tbl%0d_bc", v),     bc_m, 0);
      chk($sformatf("tbl%0d_perr", v),   perr_m, 0);
    end

    // Handshake with no completion empties the slot but keeps the data.
    idle_cycle();
    chk("drain_ov", ov_m, 0);
    chk("drain_po", po_m, 4'b1101);

    // Overrun: consumer stalled across two frames.
    out_ready = 1'b0;
    send_word(4'b1100);
    chk("ovr_first_po", po_m, 4'b1100);
    chk("ovr_first_orun", orun_m, 0);
    send_word(4'b0011);
    chk("ovr_po_held", po_m, 4'b1100);
    chk("ovr_orun", orun_m, 1);
    chk("ovr_ov", ov_m, 1);
    clear = 1'b1;
    idle_cycle();
    clear = 1'b0;
    chk("clr_orun", orun_m, 0);
    chk("clr_ov", ov_m, 1);
    chk("clr_po", po_m, 4'b1100);

    // Completion on the same edge as a drain loads the new word.
    out_ready = 1'b1;
    idle_cycle();
    out_ready = 1'b0;
    send_word(4'b1010);
    chk("sim_old_po", po_m, 4'b1010);
    send_frame(4'b0110, 1'b0, 1'b1);
    out_ready = 1'b0;
    chk("sim_po", po_m, 4'b0110);
    chk("sim_ov", ov_m, 1);
    chk("sim_orun", orun_m, 0);

    // Gaps inside a frame hold the counter.
    out_ready = 1'b1;
    send_bit(1'b1);
    idle_cycle();
    idle_cycle();
    chk("gap_bc", bc_m, 1);
    send_bit(1'b0);
    chk("gap_bc2", bc_m, 2);

    // Clear mid-frame restarts the frame with no stale bits.
    clear = 1'b1;
    idle_cycle();
    clear = 1'b0;
    chk("clr_bc", bc_m, 0);
    send_word(4'b0101);
    chk("clr_next_po", po_m, 4'b0101);

    // Asynchronous reset mid-frame.
    send_bit(1'b1);
    send_bit(1'b0);
    chk("pre_rst_bc", bc_m, 2);
    reset = 1'b1;
    #1;
    chk("async_rst_bc", bc_m, 0);
    chk("async_rst_ov", ov_m, 0);
    chk("async_rst_po", po_m, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_word(4'b1111);
    chk("post_rst_po", po_m, 4'b1111);
    chk("post_rst_po_lsb", po_l, 4'b1111);

`ifdef SIPO_DESER_PARITY_EN
    send_frame(4'b1011, 1'b1, 1'b0);
    chk("par_ok_po", po_m, 4'b1011);
    chk("par_ok_err", perr_m, 0);
    send_frame(4'b1011, 1'b0, 1'b0);
    chk("par_bad_err", perr_m, 1);
    // A dropped word must not touch parity_err.
    out_ready = 1'b0;
    send_frame(4'b0000, 1'b0, 1'b0);
    chk("par_drop_err", perr_m, 1);
    chk("par_drop_orun", orun_m, 1);
`else
    chk("nopar_err", perr_m, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
